vga_sync_decoder: RTL
=====================

// Module: vga_sync_decoder
// PURPOSE
// - Sink-side counterpart of the pixel-clock / horizontal timing generator: recovers raster position from hsync/vsync/dataValid.
// - Measures incoming line/frame geometry and asserts locked once timing is stable.
// - Sits in the pixelClk domain in front of capture, overlay or checker logic.
// - Also serves as the self-check monitor for the timing generator.
// PARAMETERS
// - XW          10  width of column counters, activeWidth, lineTotal
// - YW          10  width of row counters, activeHeight
// - LOCK_FRAMES 2   consecutive matching frames (after reference capture) needed to lock
// - HSYNC_POL   0   active level of hsync (0 = active-low); ignored when SYNC_POL_DETECT_EN is defined
// - VSYNC_POL   0   active level of vsync; ignored when SYNC_POL_DETECT_EN is defined
// PORTS
// - pixelClk      in   1   pixel clock, all logic on rising edge
// - rst           in   1   synchronous, active-high reset
// - hsync         in   1   horizontal sync from timing source
// - vsync         in   1   vertical sync from timing source
// - dataValid     in   1   active-video enable (DE)
// - pixelX        out  XW  column index within active line
// - pixelY        out  YW  row index within active frame
// - pixelValid    out  1   dataValid delayed to align with pixelX/pixelY
// - lineStart     out  1   1-cycle pulse on hsync leading edge
// - frameStart    out  1   1-cycle pulse on vsync leading edge
// - activeWidth   out  XW  DE-high cycles in last completed line
// - activeHeight  out  YW  active lines in last completed frame
// - lineTotal     out  XW  pixelClk cycles between last two hsync leading edges
// - locked        out  1   timing stable
// - timingErr     out  1   sticky; set on mismatch while LOCKED, cleared only by rst
// BEHAVIOUR
// - rst: every output 0, counters 0, FSM = SEARCH, on the next edge; takes effect mid-line or mid-frame.
// - Input handling:
//   - Inputs registered once, then normalised to active-high.
//   - Leading edge = 0->1 on the normalised sync.
//   - pixelX/pixelY/pixelValid lag the input DE sample by 2 cycles.
// - Column counter:
//   - Cleared on DE rise; +1 per DE-high cycle.
//   - Saturates at all-ones; saturation counts as a mismatch.
//   - activeWidth latched on DE fall.
// - Row counter:
//   - Cleared on vsync leading edge; +1 on each DE fall.
//   - activeHeight latched on vsync leading edge, before the clear.
// - Line-length counter:
//   - Counts every cycle; on hsync leading edge, value+1 is latched to lineTotal and the counter is cleared.
//   - Saturates; saturation counts as a mismatch.
// - Same-cycle hsync and vsync leading edges: process the line first, then the frame. lineStart and frameStart pulse together.
// - FSM states: SEARCH, MEASURE, VERIFY, LOCKED.
//   - SEARCH -> MEASURE on first vsync leading edge.
//   - MEASURE -> VERIFY at next vsync edge:
//     - reference W/H/T captured (W = activeWidth, H = activeHeight, T = lineTotal);
//     - matchCnt cleared.
//   - VERIFY, at each vsync edge: if the frame matches the reference, matchCnt++; else recapture the reference and clear matchCnt.
//   - VERIFY -> LOCKED when matchCnt reaches LOCK_FRAMES.
//   - LOCKED, on any latched line or frame value != reference:
//     - timingErr set, FSM -> SEARCH;
//     - locked drops on the same edge as the FSM change.
// - locked = (state == LOCKED), registered.
// - DE with no prior vsync in SEARCH: counters run, locked stays 0.
// CONFIGURATION
// - SYNC_POL_DETECT_EN defined:
//   - each sync's inactive level is sampled at every DE rise; active polarity = inverse of that level;
//   - HSYNC_POL/VSYNC_POL are unused;
//   - a polarity change while LOCKED is treated as a mismatch.
// - SYNC_POL_DETECT_EN undefined: polarity fixed by HSYNC_POL/VSYNC_POL; no detection logic is built.
// TESTING
// - Reset, then 5 frames of 640x480 (H 800, hsync 96 low; V 525, vsync 2 low):
//   - locked=1 one cycle after the 4th vsync edge;
//   - activeWidth=640, lineTotal=800, activeHeight=480.
// - Same stimulus: pixelX runs 0..639 and pixelY 0..479, aligned with pixelValid (2-cycle lag); frameStart pulses once per 525 lines.
// - Locked, then one line shortened to 799 total: timingErr=1, locked=0, FSM=SEARCH; relocks 4 vsync edges later, timingErr still 1.
// - rst pulsed mid-line at pixelX=300: next cycle all outputs 0; relock follows normal sequence.
// - hsync and vsync leading edges in the same cycle: lineStart=frameStart=1 together; activeHeight=480.
// - Active-high syncs: locks with SYNC_POL_DETECT_EN; never locks without it and HSYNC_POL=0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_decoder
// Desc     : Recovers raster position from hsync/vsync/DE, measures line and
//            frame geometry and reports lock once timing is stable.
// Config   : define SYNC_POL_DETECT_EN to learn sync polarity from the input
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_decoder #(
    parameter int XW          = 10,
    parameter int YW          = 10,
    parameter int LOCK_FRAMES = 2,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0
) (
    input  logic          pixelClk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          dataValid,
    output logic [XW-1:0] pixelX,
    output logic [YW-1:0] pixelY,
    output logic          pixelValid,
    output logic          lineStart,
    output logic          frameStart,
    output logic [XW-1:0] activeWidth,
    output logic [YW-1:0] activeHeight,
    output logic [XW-1:0] lineTotal,
    output logic          locked,
    output logic          timingErr
);

    localparam int            MW          = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [XW-1:0] C_X_MAX     = '1;
    localparam logic [YW-1:0] C_Y_MAX     = '1;
    localparam logic [MW-1:0] C_LOCK_LAST = MW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        VERIFY  = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_hs_q, r_vs_q, r_de_q;
    logic          r_hs_prev, r_vs_prev, r_de_prev;
    logic          w_hs, w_vs, w_hs_edge, w_vs_edge, w_de_rise, w_de_fall;
    logic          w_pol_change;
    logic [XW-1:0] r_col, r_line, w_total_new, w_width_now, w_total_now;
    logic [YW-1:0] r_row, w_row_next;
    logic          w_col_sat, w_line_sat;
    logic [XW-1:0] r_ref_w, r_ref_t;
    logic [YW-1:0] r_ref_h;
    logic [MW-1:0] r_match;
    logic          r_frame_bad, w_line_bad, w_sync_in_de, w_frame_ok;

    // Previous-level registers reset high so a sync already active at reset
    // release is not taken as a leading edge.
    always_ff @(posedge pixelClk) begin
        if (rst) begin
            r_hs_q    <= 1'b0;
            r_vs_q    <= 1'b0;
            r_de_q    <= 1'b0;
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
            r_de_prev <= 1'b0;
        end else begin
            r_hs_q    <= hsync;
            r_vs_q    <= vsync;
            r_de_q    <= dataValid;
            r_hs_prev <= w_hs;
            r_vs_prev <= w_vs;
            r_de_prev <= r_de_q;
        end
    end

`ifdef SYNC_POL_DETECT_EN
    logic r_hs_pol, r_vs_pol;

    // Syncs are idle at the start of active video, so their level there is
    // the inactive level.
    always_ff @(posedge pixelClk) begin
        if (rst) begin
            r_hs_pol <= 1'b0;
            r_vs_pol <= 1'b0;
        end else if (w_de_rise) begin
            r_hs_pol <= ~r_hs_q;
            r_vs_pol <= ~r_vs_q;
        end
    end

    assign w_hs         = (r_hs_q == r_hs_pol);
    assign w_vs         = (r_vs_q == r_vs_pol);
    assign w_pol_change = w_de_rise & (((~r_hs_q) != r_hs_pol) | ((~r_vs_q) != r_vs_pol));
`else
    assign w_hs         = (r_hs_q == HSYNC_POL);
    assign w_vs         = (r_vs_q == VSYNC_POL);
    assign w_pol_change = 1'b0;
`endif

    assign w_hs_edge   = w_hs & ~r_hs_prev;
    assign w_vs_edge   = w_vs & ~r_vs_prev;
    assign w_de_rise   = r_de_q & ~r_de_prev;
    assign w_de_fall   = ~r_de_q & r_de_prev;

    assign w_col_sat   = r_de_q & ~w_de_rise & (r_col == C_X_MAX);
    assign w_line_sat  = (r_line == C_X_MAX);
    assign w_total_new = w_line_sat ? r_line : r_line + 1'b1;
    assign w_row_next  = (w_de_fall && (r_row != C_Y_MAX)) ? r_row + 1'b1 : r_row;

    always_ff @(posedge pixelClk) begin
        if (rst) begin
            pixelX       <= '0;
            pixelY       <= '0;
            pixelValid   <= 1'b0;
            lineStart    <= 1'b0;
            frameStart   <= 1'b0;
            activeWidth  <= '0;
            activeHeight <= '0;
            lineTotal    <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_line       <= '0;
        end else begin
            pixelValid <= r_de_q;
            lineStart  <= w_hs_edge;
            frameStart <= w_vs_edge;
            if (r_de_q) begin
                pixelX <= w_de_rise ? '0 : r_col;
                pixelY <= r_row;
            end

            if (w_de_rise) begin
                r_col <= XW'(1);
            end else if (r_de_q && !w_col_sat) begin
                r_col <= r_col + 1'b1;
            end
            if (w_de_fall) begin
                activeWidth <= r_col;
            end

            if (w_hs_edge) begin
                lineTotal <= w_total_new;
                r_line    <= '0;
            end else if (!w_line_sat) begin
                r_line <= r_line + 1'b1;
            end

            // The row count already includes a DE fall in this same cycle.
            if (w_vs_edge) begin
                activeHeight <= w_row_next;
                r_row        <= '0;
            end else begin
                r_row <= w_row_next;
            end
        end
    end

    assign w_width_now  = w_de_fall ? r_col : activeWidth;
    assign w_total_now  = w_hs_edge ? w_total_new : lineTotal;
    assign w_line_bad   = (w_de_fall & (r_col != r_ref_w))
                        | (w_hs_edge & (w_total_new != r_ref_t))
                        | w_col_sat | w_line_sat | w_pol_change;
    // A sync asserted during active video means the assumed polarity is
    // wrong; such a frame never counts toward lock.
    assign w_sync_in_de = r_de_q & (w_hs | w_vs);
    assign w_frame_ok   = ~r_frame_bad & ~w_line_bad & ~w_sync_in_de
                        & (w_row_next == r_ref_h);

    always_ff @(posedge pixelClk) begin
        if (rst) begin
            r_state     <= SEARCH;
            locked      <= 1'b0;
            timingErr   <= 1'b0;
            r_match     <= '0;
            r_ref_w     <= '0;
            r_ref_h     <= '0;
            r_ref_t     <= '0;
            r_frame_bad <= 1'b0;
        end else begin
            if (w_vs_edge) begin
                r_frame_bad <= 1'b0;
            end else if (w_line_bad || w_sync_in_de) begin
                r_frame_bad <= 1'b1;
            end

            case (r_state)
                SEARCH: begin
                    if (w_vs_edge) begin
                        r_state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (w_vs_edge) begin
                        r_ref_w <= w_width_now;
                        r_ref_h <= w_row_next;
                        r_ref_t <= w_total_now;
                        r_match <= '0;
                        r_state <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_vs_edge) begin
                        if (w_frame_ok) begin
                            r_match <= r_match + 1'b1;
                            if (r_match == C_LOCK_LAST) begin
                                r_state <= LOCKED;
                                locked  <= 1'b1;
                            end
                        end else begin
                            r_ref_w <= w_width_now;
                            r_ref_h <= w_row_next;
                            r_ref_t <= w_total_now;
                            r_match <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (w_line_bad || (w_vs_edge && (w_row_next != r_ref_h))) begin
                        timingErr <= 1'b1;
                        locked    <= 1'b0;
                        r_state   <= SEARCH;
                    end
                end
                default: begin
                    r_state <= SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
